// File: rtl/usb2_ulpi_phy.sv
// usb2_ulpi_phy: PHY-side ULPI responder facing the link.
// Serves registers, captures transmits, injects RX_CMDs and packets.
module usb2_ulpi_phy #(
    parameter logic [15:0] VENDOR_ID    = 16'h0424,
    parameter logic [15:0] PRODUCT_ID   = 16'h0009,
    parameter int unsigned RESET_CYCLES = 32
) (
    input  logic       phy_clk,
    input  logic       reset,
    input  logic [7:0] phy_d_in,
    output logic [7:0] phy_d_out,
    output logic       phy_dir,
    output logic       phy_nxt,
    input  logic       phy_stp,
    input  logic [1:0] line_state,
    input  logic [1:0] vbus_state,
    input  logic       id_gnd,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       rx_last,
    output logic       rx_ready,
    output logic [3:0] tx_pid,
    output logic [7:0] tx_byte,
    output logic       tx_strobe,
    output logic       tx_eop,
    output logic       tx_abort,
    output logic [7:0] reg_func_ctrl,
    output logic [7:0] reg_otg_ctrl
);

    typedef enum logic [3:0] {
        IDLE, CMD_ACK, EXT_WAIT, REGW_DATA, REGW_STP,
        REGR_TA, REGR_DATA, TX_DATA, EV_TA, EV_CMD,
        RX_TA, RX_XFER, RX_LAST, RX_EOP, RST_HOLD, RST_GAP
    } state_t;

    state_t      state_q, state_d;
    logic        dir_q, dir_d, nxt_q, nxt_d;
    logic [7:0]  dout_q, dout_d;
    logic        rdy_q, rdy_d, stb_q, stb_d;
    logic        eop_q, eop_d, abt_q, abt_d;
    logic [7:0]  txb_q, txb_d;
    logic [3:0]  pid_q, pid_d;
    logic [7:0]  func_q, func_d, iface_q, iface_d, otg_q, otg_d;
    logic [3:0]  last_q, last_d;
    logic [7:0]  cmd_q, cmd_d, wdata_q, wdata_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  rd_val, wr_val, ev_cmd, act_cmd;

    assign ev_cmd  = {1'b0, id_gnd, 2'b00, vbus_state, line_state};
    assign act_cmd = {1'b0, id_gnd, 2'b01, vbus_state, line_state};

    // Set/clear aliases read back the base register value
    always_comb begin
        unique case (cmd_q[5:0])
            6'h00:               rd_val = VENDOR_ID[7:0];
            6'h01:               rd_val = VENDOR_ID[15:8];
            6'h02:               rd_val = PRODUCT_ID[7:0];
            6'h03:               rd_val = PRODUCT_ID[15:8];
            6'h04, 6'h05, 6'h06: rd_val = func_q;
            6'h07, 6'h08, 6'h09: rd_val = iface_q;
            6'h0A, 6'h0B, 6'h0C: rd_val = otg_q;
            default:             rd_val = 8'h00;
        endcase
    end

    always_comb begin
        wr_val = wdata_q;
        unique case (cmd_q[5:0])
            6'h05, 6'h08, 6'h0B: wr_val = rd_val | wdata_q;
            6'h06, 6'h09, 6'h0C: wr_val = rd_val & ~wdata_q;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        dir_d   = 1'b0;
        nxt_d   = 1'b0;
        dout_d  = 8'h00;
        rdy_d   = 1'b0;
        stb_d   = 1'b0;
        eop_d   = 1'b0;
        abt_d   = 1'b0;
        txb_d   = txb_q;
        pid_d   = pid_q;
        func_d  = func_q;
        iface_d = iface_q;
        otg_d   = otg_q;
        last_d  = last_q;
        cmd_d   = cmd_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (phy_d_in[7:6] != 2'b00) begin
                    cmd_d = phy_d_in;
                    if (phy_d_in[7] && phy_d_in[5:0] == 6'h2F) begin
                        state_d = EXT_WAIT;
                    end else begin
                        state_d = CMD_ACK;
                        nxt_d   = 1'b1;
                        if (phy_d_in[7:6] == 2'b01) pid_d = phy_d_in[3:0];
                    end
                end else if (phy_d_in == 8'h00 && !phy_stp) begin
                    if (rx_valid) begin
                        state_d = RX_TA;
                        dir_d   = 1'b1;
                        nxt_d   = 1'b1;
                    end else if ({line_state, vbus_state} != last_q) begin
                        state_d = EV_TA;
                        dir_d   = 1'b1;
                    end
                end
            end
            EXT_WAIT: if (phy_d_in == 8'h00) state_d = IDLE;
            CMD_ACK: begin
                unique case (cmd_q[7:6])
                    2'b10: begin
                        state_d = REGW_DATA;
                        nxt_d   = 1'b1;
                    end
                    2'b11: begin
                        state_d = REGR_TA;
                        dir_d   = 1'b1;
                    end
                    default: begin
                        state_d = TX_DATA;
                        nxt_d   = 1'b1;
                    end
                endcase
            end
            REGW_DATA: begin
                wdata_d = phy_d_in;
                state_d = REGW_STP;
            end
            REGW_STP: begin
                if (phy_stp) begin
                    state_d = IDLE;
                    unique case (cmd_q[5:0])
                        6'h04, 6'h05, 6'h06: begin
                            func_d = wr_val & 8'hDF;
                            if (wr_val[5]) begin
                                state_d = RST_HOLD;
                                dir_d   = 1'b1;
                                cnt_d   = '0;
                            end
                        end
                        6'h07, 6'h08, 6'h09: iface_d = wr_val;
                        6'h0A, 6'h0B, 6'h0C: otg_d = wr_val;
                        default: ;
                    endcase
                end
            end
            REGR_TA: begin
                dir_d   = 1'b1;
                dout_d  = rd_val;
                state_d = REGR_DATA;
            end
            REGR_DATA: state_d = IDLE;
            TX_DATA: begin
                if (phy_stp) begin
                    state_d = IDLE;
                    abt_d   = (phy_d_in == 8'hFF);
                    eop_d   = (phy_d_in != 8'hFF);
                end else begin
                    nxt_d = 1'b1;
                    stb_d = 1'b1;
                    txb_d = phy_d_in;
                end
            end
            EV_TA: begin
                dir_d   = 1'b1;
                dout_d  = ev_cmd;
                last_d  = {line_state, vbus_state};
                state_d = EV_CMD;
            end
            EV_CMD: state_d = IDLE;
            RX_TA: begin
                dir_d   = 1'b1;
                dout_d  = act_cmd;
                state_d = RX_XFER;
            end
            RX_XFER: begin
                dir_d = 1'b1;
                if (rx_valid) begin
                    dout_d = rx_byte;
                    nxt_d  = 1'b1;
                    rdy_d  = 1'b1;
                    if (rx_last) state_d = RX_LAST;
                end else begin
                    dout_d = act_cmd;
                end
            end
            RX_LAST: begin
                dir_d   = 1'b1;
                dout_d  = ev_cmd;
                state_d = RX_EOP;
            end
            RX_EOP: state_d = IDLE;
            RST_HOLD: begin
                if (cnt_q == 16'(RESET_CYCLES - 1)) begin
                    state_d = RST_GAP;
                end else begin
                    dir_d = 1'b1;
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RST_GAP: begin
                state_d = EV_TA;
                dir_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge phy_clk) begin
        if (reset) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            nxt_q   <= 1'b0;
            dout_q  <= 8'h00;
            rdy_q   <= 1'b0;
            stb_q   <= 1'b0;
            eop_q   <= 1'b0;
            abt_q   <= 1'b0;
            txb_q   <= 8'h00;
            pid_q   <= 4'h0;
            func_q  <= 8'h41;
            iface_q <= 8'h00;
            otg_q   <= 8'h06;
            last_q  <= {line_state, vbus_state};
            cmd_q   <= 8'h00;
            wdata_q <= 8'h00;
            cnt_q   <= 16'h0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            nxt_q   <= nxt_d;
            dout_q  <= dout_d;
            rdy_q   <= rdy_d;
            stb_q   <= stb_d;
            eop_q   <= eop_d;
            abt_q   <= abt_d;
            txb_q   <= txb_d;
            pid_q   <= pid_d;
            func_q  <= func_d;
            iface_q <= iface_d;
            otg_q   <= otg_d;
            last_q  <= last_d;
            cmd_q   <= cmd_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign phy_d_out     = dout_q;
    assign phy_dir       = dir_q;
    assign phy_nxt       = nxt_q;
    assign rx_ready      = rdy_q;
    assign tx_pid        = pid_q;
    assign tx_byte       = txb_q;
    assign tx_strobe     = stb_q;
    assign tx_eop        = eop_q;
    assign tx_abort      = abt_q;
    assign reg_func_ctrl = func_q;
    assign reg_otg_ctrl  = otg_q;

endmodule
